// File: rtl/uart_reg_bridge.sv
// Parses UART host frames (write 57/addr/4 data, read 52/addr) into single-cycle register-bus accesses.
// Latency: write strobe 1 cycle after the last data byte; response bytes go out once the transmitter reports idle.
// Backpressure: each response byte waits for i_tx_status to rise and then fall; rx bytes arriving while busy are dropped.
module uart_reg_bridge #(
    parameter int BYTE_TIMEOUT = 417000,
    parameter int RD_TIMEOUT   = 255
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        i_rx_dvalid,
    input  logic [7:0]  i_rx_data,
    output logic        o_tx_dvalid,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_status,
    output logic        o_reg_wr_en,
    output logic        o_reg_rd_en,
    output logic [7:0]  o_reg_addr,
    output logic [31:0] o_reg_wdata,
    input  logic [31:0] i_reg_rdata,
    input  logic        i_reg_rd_valid,
    output logic        o_frame_err
);

    localparam int TMAX = (BYTE_TIMEOUT > RD_TIMEOUT) ? BYTE_TIMEOUT : RD_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;

    typedef enum logic [3:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        REG_WR,
        REG_RD,
        WAIT_RD,
        TX_SEND,
        TX_WAIT_BUSY,
        TX_WAIT_DONE
    } state_t;

    state_t        state;
    logic          is_write;
    logic [1:0]    data_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [31:0]   tx_buf;
    logic [2:0]    tx_cnt;
    logic          rst_meta;
    logic          rst_n_sync;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rst_meta   <= 1'b0;
            rst_n_sync <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_n_sync <= rst_meta;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state       <= IDLE;
            is_write    <= 1'b0;
            data_cnt    <= 2'd0;
            tmo_cnt     <= '0;
            tx_buf      <= 32'h0;
            tx_cnt      <= 3'd0;
            o_tx_dvalid <= 1'b0;
            o_tx_data   <= 8'h0;
            o_reg_wr_en <= 1'b0;
            o_reg_rd_en <= 1'b0;
            o_reg_addr  <= 8'h0;
            o_reg_wdata <= 32'h0;
            o_frame_err <= 1'b0;
        end else begin
            o_tx_dvalid <= 1'b0;
            o_reg_wr_en <= 1'b0;
            o_reg_rd_en <= 1'b0;
            o_frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_rx_dvalid) begin
                        if (i_rx_data == CMD_WR || i_rx_data == CMD_RD) begin
                            is_write <= (i_rx_data == CMD_WR);
                            tmo_cnt  <= '0;
                            state    <= GET_ADDR;
                        end else begin
                            o_frame_err <= 1'b1;
                            tx_buf      <= {RSP_ERR, 24'h0};
                            tx_cnt      <= 3'd1;
                            state       <= TX_SEND;
                        end
                    end
                end

                GET_ADDR: begin
                    if (i_rx_dvalid) begin
                        o_reg_addr <= i_rx_data;
                        tmo_cnt    <= '0;
                        data_cnt   <= 2'd0;
                        if (is_write) begin
                            state <= GET_DATA;
                        end else begin
                            o_reg_rd_en <= 1'b1;
                            state       <= REG_RD;
                        end
                    end else if (tmo_cnt == TW'(BYTE_TIMEOUT - 1)) begin
                        o_frame_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                GET_DATA: begin
                    if (i_rx_dvalid) begin
                        o_reg_wdata <= {o_reg_wdata[23:0], i_rx_data};
                        tmo_cnt     <= '0;
                        data_cnt    <= data_cnt + 1'b1;
                        // Strobe is raised here so it is visible the cycle after the last byte.
                        if (data_cnt == 2'd3) begin
                            o_reg_wr_en <= 1'b1;
                            state       <= REG_WR;
                        end
                    end else if (tmo_cnt == TW'(BYTE_TIMEOUT - 1)) begin
                        o_frame_err <= 1'b1;
                        data_cnt    <= 2'd0;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                REG_WR: begin
                    tx_buf <= {RSP_ACK, 24'h0};
                    tx_cnt <= 3'd1;
                    state  <= TX_SEND;
                end

                REG_RD: begin
                    tmo_cnt <= '0;
                    if (i_reg_rd_valid) begin
                        tx_buf <= i_reg_rdata;
                        tx_cnt <= 3'd4;
                        state  <= TX_SEND;
                    end else begin
                        state <= WAIT_RD;
                    end
                end

                WAIT_RD: begin
                    if (i_reg_rd_valid) begin
                        tx_buf <= i_reg_rdata;
                        tx_cnt <= 3'd4;
                        state  <= TX_SEND;
                    end else if (tmo_cnt == TW'(RD_TIMEOUT - 1)) begin
                        o_frame_err <= 1'b1;
                        tx_buf      <= {RSP_ERR, 24'h0};
                        tx_cnt      <= 3'd1;
                        state       <= TX_SEND;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                TX_SEND: begin
                    // Never request while the transmitter still reports busy.
                    if (!i_tx_status) begin
                        o_tx_data   <= tx_buf[31:24];
                        o_tx_dvalid <= 1'b1;
                        state       <= TX_WAIT_BUSY;
                    end
                end

                TX_WAIT_BUSY: begin
                    if (i_tx_status) begin
                        state <= TX_WAIT_DONE;
                    end
                end

                TX_WAIT_DONE: begin
                    if (!i_tx_status) begin
                        tx_buf <= {tx_buf[23:0], 8'h0};
                        tx_cnt <= tx_cnt - 1'b1;
                        state  <= (tx_cnt == 3'd1) ? IDLE : TX_SEND;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_reg_bridge.md
Name: uart_reg_bridge

Overview:
- Host-command layer directly downstream of the UART receiver and upstream of the UART transmitter.
- Consumes received bytes (rx_dvalid/rx_data) and parses fixed-length read/write frames.
- Issues single-cycle accesses on the FPGA register bus, then returns a response through the transmitter's dvalid/data/status handshake.

Parameters:
- BYTE_TIMEOUT, 417000, sys_clk cycles allowed between bytes of one frame before the partial frame is discarded.
- RD_TIMEOUT, 255, sys_clk cycles to wait for i_reg_rd_valid after o_reg_rd_en.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge
- sys_rst_n  in  1  asynchronous active-low reset
- i_rx_dvalid  in  1  one-cycle strobe, received byte valid
- i_rx_data  in  8  received byte
- o_tx_dvalid  out  1  one-cycle request to transmit o_tx_data
- o_tx_data  out  8  byte to transmit; held stable until transmitter is idle again
- i_tx_status  in  1  transmitter busy (rises the cycle after an accepted o_tx_dvalid)
- o_reg_wr_en  out  1  one-cycle write strobe
- o_reg_rd_en  out  1  one-cycle read strobe
- o_reg_addr  out  8  register address
- o_reg_wdata  out  32  write data
- i_reg_rdata  in  32  read data, valid with i_reg_rd_valid
- i_reg_rd_valid  in  1  read data strobe
- o_frame_err  out  1  one-cycle pulse on bad command, byte timeout or read timeout

Behaviour:
- Reset (async assert, sync release on sys_clk):
  - All outputs 0.
  - State IDLE; counters and buffers cleared.
- Frame format:
  - Write: 0x57, addr, d[31:24], d[23:16], d[15:8], d[7:0]. Response is 0x4B.
  - Read: 0x52, addr. Response is rdata MSB byte first (4 bytes).
  - Error response is the single byte 0x45.
- States:
  - IDLE: on rx byte 0x57 or 0x52, latch the command and go to GET_ADDR. On any other byte, pulse o_frame_err, load 0x45 and go to TX_SEND.
  - GET_ADDR: on rx byte, latch o_reg_addr. A write goes to GET_DATA with byte count 0; a read goes to REG_RD.
  - GET_DATA: each rx byte shifts into o_reg_wdata from the MSB side. After the 4th byte, go to REG_WR.
  - REG_WR: assert o_reg_wr_en for exactly 1 cycle, load 0x4B (count 1), go to TX_SEND.
    - Write strobe fires 1 cycle after the last data byte's rx_dvalid.
  - REG_RD: assert o_reg_rd_en for 1 cycle, clear the timeout counter, go to WAIT_RD.
  - WAIT_RD: i_reg_rd_valid (including the same cycle as rd_en's deassertion) latches i_reg_rdata into the 32-bit response buffer (count 4) and goes to TX_SEND. If RD_TIMEOUT cycles elapse first, pulse o_frame_err, load 0x45 and go to TX_SEND.
  - TX_SEND: o_tx_data = buffer[31:24] (or the single byte); o_tx_dvalid=1 for 1 cycle; go to TX_WAIT_BUSY.
  - TX_WAIT_BUSY: wait for i_tx_status=1, then go to TX_WAIT_DONE.
  - TX_WAIT_DONE: wait for i_tx_status=0. Then shift the buffer left 8 and decrement the count; if the count is nonzero go to TX_SEND, else go to IDLE.
- o_tx_dvalid is never asserted while i_tx_status=1. o_tx_data is unchanged from TX_SEND until TX_WAIT_DONE exits.
- Byte timeout:
  - Applies in GET_ADDR and GET_DATA only.
  - The counter resets on every rx byte.
  - At BYTE_TIMEOUT: pulse o_frame_err, discard the partial frame, return to IDLE silently (no response).
- Half-duplex: rx bytes arriving in REG_*, WAIT_RD or TX_* states are dropped without error.
- Write data is kept in o_reg_wdata after the write; o_reg_addr is held until the next frame's address byte.
- Strobes o_reg_wr_en, o_reg_rd_en, o_tx_dvalid and o_frame_err are mutually exclusive in any cycle.
- Reset mid-frame or mid-transmit: immediate return to IDLE and all outputs 0. The partial UART byte is the transmitter's concern.

Test Plan:
- Write frame 57 10 DE AD BE EF -> 1-cycle o_reg_wr_en, addr=0x10, wdata=0xDEADBEEF; tx emits 0x4B once.
- Read frame 52 20, i_reg_rdata=0x12345678 with rd_valid 3 cycles after rd_en -> tx bytes 12,34,56,78 in order; each dvalid issued only after status falls.
- Bad command byte 0xAA -> o_frame_err pulse, tx 0x45, no register strobe; following valid frame processed normally.
- Send 57 10 DE, then idle BYTE_TIMEOUT cycles -> o_frame_err, no wr_en, no tx; next 52 00 frame works.
- Read with i_reg_rd_valid never asserted -> o_frame_err after RD_TIMEOUT, tx 0x45.
- Assert sys_rst_n=0 during the 2nd response byte of a read -> all outputs 0 asynchronously; after release the bridge accepts a new frame.
